// File: rtl/axil_cfg_regs.sv
// AXI4-Lite responder for the shell's pipeline configuration: ID, scratch, packet counter,
// sticky W1C error status, and the CTRL / QID_MAP fields consumed by the H2C/C2H datapath.
module axil_cfg_regs #(
  parameter int unsigned ADDR_W         = 32,
  parameter logic [31:0] ID_VALUE       = 32'h4D454E53,
  parameter logic [31:0] UNMAPPED_RDATA = 32'h00000000
) (
  input  logic              axil_aclk,
  input  logic              axil_aresetn,
  input  logic              s_axil_awvalid,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  output logic              s_axil_awready,
  input  logic              s_axil_wvalid,
  input  logic [31:0]       s_axil_wdata,
  output logic              s_axil_wready,
  output logic              s_axil_bvalid,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_bready,
  input  logic              s_axil_arvalid,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  output logic              s_axil_arready,
  output logic              s_axil_rvalid,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  input  logic              s_axil_rready,
  input  logic              pkt_inc,
  input  logic [7:0]        err_set,
  output logic [31:0]       cfg_ctrl,
  output logic [31:0]       cfg_qid_map
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_ID, REG_SCRATCH, REG_PKT_CNT, REG_ERR, REG_CTRL, REG_QID_MAP, REG_NONE
  } reg_sel_e;

  // The two low address bits are don't-care; everything above must match exactly.
  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = addr & ~ADDR_W'(3);
    case (word)
      ADDR_W'(32'h0000_0000): return REG_ID;
      ADDR_W'(32'h0000_0004): return REG_SCRATCH;
      ADDR_W'(32'h0000_0008): return REG_PKT_CNT;
      ADDR_W'(32'h0000_000C): return REG_ERR;
      ADDR_W'(32'h0000_1000): return REG_CTRL;
      ADDR_W'(32'h0000_2000): return REG_QID_MAP;
      default:                return REG_NONE;
    endcase
  endfunction

  logic        aw_latched, w_latched;
  logic        aw_latched_d, w_latched_d, bvalid_d, rvalid_d;
  reg_sel_e    wr_sel, rd_sel;
  logic [31:0] wdata_q;
  logic [31:0] scratch, pkt_cnt;
  logic [7:0]  err, err_clr;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;

  assign aw_hs  = s_axil_awvalid & s_axil_awready;
  assign w_hs   = s_axil_wvalid  & s_axil_wready;
  assign b_hs   = s_axil_bvalid  & s_axil_bready;
  assign ar_hs  = s_axil_arvalid & s_axil_arready;
  assign r_hs   = s_axil_rvalid  & s_axil_rready;
  assign commit = aw_latched & w_latched & ~s_axil_bvalid;
  assign rd_sel = decode(s_axil_araddr);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    aw_latched_d = aw_latched;
    w_latched_d  = w_latched;
    bvalid_d     = s_axil_bvalid;
    if (aw_hs) aw_latched_d = 1'b1;
    if (w_hs)  w_latched_d  = 1'b1;
    if (commit) begin
      aw_latched_d = 1'b0;
      w_latched_d  = 1'b0;
      bvalid_d     = 1'b1;
    end
    if (b_hs) bvalid_d = 1'b0;
  end

  always_comb begin
    wr_resp = RESP_SLVERR;
    if (wr_sel inside {REG_SCRATCH, REG_ERR, REG_CTRL, REG_QID_MAP}) wr_resp = RESP_OKAY;
    err_clr = (commit && wr_sel == REG_ERR) ? wdata_q[7:0] : 8'h00;
  end

  // Readies are registered so they stay low through reset and rise on the first edge after it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      aw_latched     <= 1'b0;
      w_latched      <= 1'b0;
      wr_sel         <= REG_NONE;
      wdata_q        <= '0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
    end else begin
      aw_latched     <= aw_latched_d;
      w_latched      <= w_latched_d;
      s_axil_bvalid  <= bvalid_d;
      s_axil_awready <= !aw_latched_d && !bvalid_d;
      s_axil_wready  <= !w_latched_d && !bvalid_d;
      if (aw_hs)  wr_sel       <= decode(s_axil_awaddr);
      if (w_hs)   wdata_q      <= s_axil_wdata;
      if (commit) s_axil_bresp <= wr_resp;
    end
  end

  // Error bits are sticky: a set pulse in the same cycle as a W1C clear wins.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      scratch     <= '0;
      pkt_cnt     <= '0;
      err         <= '0;
      cfg_ctrl    <= '0;
      cfg_qid_map <= '0;
    end else begin
      pkt_cnt <= pkt_cnt + 32'(pkt_inc);
      err     <= (err & ~err_clr) | err_set;
      if (commit) begin
        case (wr_sel)
          REG_SCRATCH: scratch     <= wdata_q;
          REG_CTRL:    cfg_ctrl    <= wdata_q;
          REG_QID_MAP: cfg_qid_map <= wdata_q;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = UNMAPPED_RDATA;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      REG_ID:      rd_data = ID_VALUE;
      REG_SCRATCH: rd_data = scratch;
      REG_PKT_CNT: rd_data = pkt_cnt;
      REG_ERR:     rd_data = {24'h0, err};
      REG_CTRL:    rd_data = cfg_ctrl;
      REG_QID_MAP: rd_data = cfg_qid_map;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  assign rvalid_d = ar_hs ? 1'b1 : (r_hs ? 1'b0 : s_axil_rvalid);

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
    end else begin
      s_axil_rvalid  <= rvalid_d;
      s_axil_arready <= !rvalid_d;
      if (ar_hs) begin
        s_axil_rdata <= rd_data;
        s_axil_rresp <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_axil_cfg_regs.sv
// Self-checking bench for axil_cfg_regs: directed scenarios plus randomized concurrent
// read/write traffic, checked against a register-level model of the configuration block.
module tb_axil_cfg_regs;

  localparam logic [31:0] ID_VALUE = 32'h4D454E53;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, cfg_ctrl, cfg_qid_map;
  logic        pkt_inc;
  logic [7:0]  err_set;

  logic        bg_en = 1'b0, bg_pkt = 1'b0, pkt_req = 1'b0;
  logic [7:0]  bg_err = 8'h0, err_req = 8'h0;
  assign pkt_inc = bg_en ? bg_pkt : pkt_req;
  assign err_set = bg_en ? bg_err : err_req;

  always #5 clk = ~clk;

  axil_cfg_regs dut (
    .axil_aclk      (clk),
    .axil_aresetn   (rst_n),
    .s_axil_awvalid (awvalid),
    .s_axil_awaddr  (awaddr),
    .s_axil_awready (awready),
    .s_axil_wvalid  (wvalid),
    .s_axil_wdata   (wdata),
    .s_axil_wready  (wready),
    .s_axil_bvalid  (bvalid),
    .s_axil_bresp   (bresp),
    .s_axil_bready  (bready),
    .s_axil_arvalid (arvalid),
    .s_axil_araddr  (araddr),
    .s_axil_arready (arready),
    .s_axil_rvalid  (rvalid),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rready  (rready),
    .pkt_inc        (pkt_inc),
    .err_set        (err_set),
    .cfg_ctrl       (cfg_ctrl),
    .cfg_qid_map    (cfg_qid_map)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- register-level model ----------------
  logic [31:0] m_scratch, m_ctrl, m_qid, m_cnt;
  logic [7:0]  m_err;
  logic        m_wr_pending = 1'b0;
  logic [31:0] m_wr_addr = '0, m_wr_data = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [1:0] model_wresp(input logic [31:0] a);
    logic [31:0] w;
    w = word_of(a);
    return (w == 32'h4 || w == 32'hC || w == 32'h1000 || w == 32'h2000) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    case (word_of(a))
      32'h0:    d = ID_VALUE;
      32'h4:    d = m_scratch;
      32'h8:    d = m_cnt;
      32'hC:    d = {24'h0, m_err};
      32'h1000: d = m_ctrl;
      32'h2000: d = m_qid;
      default:  begin d = 32'h0; r = 2'b10; end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scratch <= '0;
      m_ctrl    <= '0;
      m_qid     <= '0;
      m_cnt     <= '0;
      m_err     <= '0;
    end else begin
      m_cnt <= m_cnt + (pkt_inc ? 32'd1 : 32'd0);
      m_err <= (m_err & ~((m_wr_pending && word_of(m_wr_addr) == 32'hC) ? m_wr_data[7:0] : 8'h0))
               | err_set;
      if (m_wr_pending) begin
        case (word_of(m_wr_addr))
          32'h4:    m_scratch <= m_wr_data;
          32'h1000: m_ctrl    <= m_wr_data;
          32'h2000: m_qid     <= m_wr_data;
          default:  ;
        endcase
      end
    end
  end

  // Per-cycle comparison of the configuration outputs and the reset state.
  always @(negedge clk) begin
    check("cfg_ctrl", cfg_ctrl, m_ctrl);
    check("cfg_qid_map", cfg_qid_map, m_qid);
    if (!rst_n) begin
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    bg_pkt = 1'($urandom_range(0, 1));
    bg_err = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h0;
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [7:0] err_pulse, output logic [1:0] got_resp);
    bit aw_done = 0, w_done = 0;
    int n = 0;
    logic [1:0] exp_resp;
    exp_resp = model_wresp(addr);
    got_resp = 2'bxx;
    @(posedge clk); #1;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (n >= aw_dly); awaddr = addr;
      wvalid  = !w_done && (n >= w_dly);   wdata  = data;
      @(negedge clk);
      if (aw_done) check("awready_held_low", awready, 0);
      if (w_done)  check("wready_held_low", wready, 0);
      check("bvalid_before_commit", bvalid, 0);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done = 1;
      n++;
      @(posedge clk); #1;
      if (n > 100) begin
        fail("write_handshake_timeout");
        awvalid = 0; wvalid = 0;
        return;
      end
    end
    awvalid = 0; wvalid = 0;
    m_wr_addr = addr; m_wr_data = data; m_wr_pending = 1;
    if (err_pulse != 8'h0) err_req = err_pulse;
    @(negedge clk);
    check("bvalid_commit_cycle", bvalid, 0);
    check("awready_commit_cycle", awready, 0);
    check("wready_commit_cycle", wready, 0);
    @(posedge clk); #1;
    m_wr_pending = 0;
    err_req = 8'h0;
    for (int k = 0; k <= b_dly; k++) begin
      bready = (k >= b_dly);
      @(negedge clk);
      check("bvalid", bvalid, 1);
      check("bresp", bresp, exp_resp);
      check("awready_during_b", awready, 0);
      check("wready_during_b", wready, 0);
      got_resp = bresp;
      if (bready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    check("bvalid_after_b", bvalid, 0);
    check("awready_after_b", awready, 1);
    check("wready_after_b", wready, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] got_data, output logic [1:0] got_resp);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int n = 0;
    got_data = 'x; got_resp = 'x;
    @(posedge clk); #1;
    repeat (ar_dly) begin @(posedge clk); #1; end
    arvalid = 1; araddr = addr;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) begin
      fail("read_ar_timeout");
      arvalid = 0;
      return;
    end
    @(posedge clk);
    model_read(addr, exp_data, exp_resp);
    #1; arvalid = 0;
    for (int k = 0; k <= r_dly; k++) begin
      rready = (k >= r_dly);
      @(negedge clk);
      check("rvalid", rvalid, 1);
      check("rdata", rdata, exp_data);
      check("rresp", rresp, exp_resp);
      check("arready_during_r", arready, 0);
      got_data = rdata; got_resp = rresp;
      if (rready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    check("rvalid_after_r", rvalid, 0);
    check("arready_after_r", arready, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rresp"}, rresp, 0);
    check({tag, "_cfg_ctrl"}, cfg_ctrl, 0);
    check({tag, "_cfg_qid_map"}, cfg_qid_map, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk); #2;
    rst_n = 0;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_awready", awready, 1);
    check("post_reset_wready", wready, 1);
    check("post_reset_arready", arready, 1);
    check("post_reset_bvalid", bvalid, 0);
  endtask

  task automatic pulse_pkt(input int n);
    repeat (n) begin
      @(posedge clk); #1 pkt_req = 1;
      @(posedge clk); #1 pkt_req = 0;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] gd, gd2;
  logic [1:0]  gr, gr2;
  logic [31:0] addrs [0:10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h1000, 32'h2000,
                                32'h3000, 32'h10, 32'h2004, 32'h1003, 32'h8000_0000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // CTRL write with AW and W together, immediate bready.
    axi_write(32'h1000, 32'h0000_0001, 0, 0, 0, 8'h0, gr);
    check("ctrl_wr_resp", gr, 2'b00);
    check("cfg_ctrl_lit", cfg_ctrl, 32'h0000_0001);
    axi_read(32'h1000, 0, 0, gd, gr);
    check("ctrl_rd_lit", gd, 32'h0000_0001);
    check("ctrl_rd_resp", gr, 2'b00);

    // QID_MAP write: AW first, W three cycles later, bready held low for 5 cycles.
    axi_write(32'h2000, 32'h0002_0001, 0, 3, 5, 8'h0, gr);
    check("qid_cfg_lit", cfg_qid_map, 32'h0002_0001);

    // ID is read-only; unmapped reads are SLVERR.
    axi_read(32'h0, 0, 0, gd, gr);
    check("id_rd_lit", gd, 32'h4D45_4E53);
    axi_write(32'h0, 32'h0, 0, 0, 0, 8'h0, gr);
    check("id_wr_slverr", gr, 2'b10);
    axi_read(32'h0, 0, 1, gd, gr);
    check("id_unchanged", gd, 32'h4D45_4E53);
    axi_read(32'h3000, 0, 0, gd, gr);
    check("unmapped_rd_data", gd, 32'h0);
    check("unmapped_rd_resp", gr, 2'b10);

    // Packet counter and W1C error with set-wins collision.
    pulse_pkt(5);
    @(posedge clk); #1 err_req = 8'h05;
    @(posedge clk); #1 err_req = 8'h00;
    axi_write(32'hC, 32'h1, 0, 0, 0, 8'h01, gr);
    check("err_wr_okay", gr, 2'b00);
    axi_read(32'hC, 0, 0, gd, gr);
    check("err_set_wins", gd, 32'h05);
    axi_read(32'h8, 0, 0, gd, gr);
    check("pkt_cnt_5", gd, 32'd5);
    axi_write(32'hC, 32'h1, 1, 0, 0, 8'h0, gr);
    axi_read(32'hC, 0, 0, gd, gr);
    check("err_w1c", gd, 32'h04);

    // SCRATCH read issued in the cycle its write commits sees the old value.
    fork
      axi_write(32'h4, 32'hA5A5_A5A5, 0, 0, 0, 8'h0, gr);
      axi_read(32'h4, 1, 0, gd, gr2);
    join
    check("scratch_precommit", gd, 32'h0);
    axi_read(32'h4, 0, 0, gd, gr);
    check("scratch_new", gd, 32'hA5A5_A5A5);

    // Randomized concurrent traffic with background pkt_inc / err_set activity.
    @(posedge clk); #1 bg_en = 1;
    for (int i = 0; i < 60; i++) begin
      fork
        axi_write(addrs[$urandom_range(0, 10)], $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 8'h0, gr);
        axi_read(addrs[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 3),
                 gd2, gr2);
      join
    end
    @(posedge clk); #1 bg_en = 0;

    // Reset with a write response pending and the counter at 7.
    apply_reset();
    pulse_pkt(7);
    axi_read(32'h8, 0, 0, gd, gr);
    check("pkt_cnt_7", gd, 32'd7);
    @(posedge clk); #1;
    awvalid = 1; awaddr = 32'h0; wvalid = 1; wdata = 32'h1234;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid_pending", bvalid, 1);
    apply_reset();
    repeat (3) begin
      @(negedge clk);
      check("no_bvalid_after_reset", bvalid, 0);
    end
    axi_read(32'h8, 0, 0, gd, gr);
    check("pkt_cnt_cleared", gd, 32'd0);
    axi_read(32'h4, 0, 0, gd, gr);
    check("scratch_cleared", gd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_cfg_regs.md
Name: axil_cfg_regs

Overview:
- AXI4-Lite responder (slave) holding the shell's pipeline configuration registers, sitting behind the host AXI4-Lite master.
- Accepts single-beat 32-bit writes and reads, with at most one outstanding transaction per direction.
- Drives the configuration fields consumed by the H2C/C2H datapath and exposes a packet counter and a write-1-to-clear (W1C) error status.

Parameters:
- ADDR_W, 32, width of awaddr/araddr
- ID_VALUE, 32'h4D454E53, constant returned by the ID register
- UNMAPPED_RDATA, 32'h00000000, rdata returned for unmapped reads

Ports:
- axil_aclk  in  1  sole clock
- axil_aresetn  in  1  asynchronous active-low reset
- s_axil_awvalid  in  1  write address valid
- s_axil_awaddr  in  ADDR_W  write address
- s_axil_awready  out  1  write address ready
- s_axil_wvalid  in  1  write data valid
- s_axil_wdata  in  32  write data; full-word writes only, no strobes
- s_axil_wready  out  1  write data ready
- s_axil_bvalid  out  1  write response valid
- s_axil_bresp  out  2  write response
- s_axil_bready  in  1  write response ready
- s_axil_arvalid  in  1  read address valid
- s_axil_araddr  in  ADDR_W  read address
- s_axil_arready  out  1  read address ready
- s_axil_rvalid  out  1  read data valid
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rready  in  1  read data ready
- pkt_inc  in  1  one-cycle pulse; increments PKT_CNT
- err_set  in  8  per-bit sticky error set pulses
- cfg_ctrl  out  32  CTRL register value
- cfg_qid_map  out  32  QID_MAP register value

Behaviour:
- Register map (addr[1:0] ignored):
  - 0x0000 ID: RO, returns ID_VALUE.
  - 0x0004 SCRATCH: RW.
  - 0x0008 PKT_CNT: RO, 32-bit, wraps 0xFFFFFFFF to 0.
  - 0x000C ERR: bits[7:0], W1C, sticky.
  - 0x1000 CTRL: RW.
  - 0x2000 QID_MAP: RW, [15:0] qid_base, [31:16] qid_num.
- Reset: every ready/valid output is 0; bresp, rresp, rdata, cfg_ctrl, cfg_qid_map, SCRATCH, PKT_CNT and ERR are all 0. awready, wready and arready rise in the first cycle after reset deasserts.
- Write channel:
  - AW and W handshake independently. awready is high while no address is latched and bvalid=0; wready likewise for data.
  - Either channel may arrive first, or both in the same cycle. A latched channel drops its ready until the write response completes.
  - The cycle after both are latched, the write commits and bvalid=1 is registered.
  - bvalid and bresp hold until bready. After the B handshake both readies reassert in the next cycle.
- Write responses:
  - OKAY (2'b00) for writes to RW registers and to ERR.
  - SLVERR (2'b10) for writes to ID or PKT_CNT (no effect) and to unmapped addresses (no effect).
- ERR write: written 1s clear the matching bits. If an err_set bit and a W1C clear of that bit land in the same cycle, the set wins.
- PKT_CNT: increments on pkt_inc every cycle, independent of bus activity.
- Read channel:
  - arready=1 while rvalid=0.
  - On an AR handshake, rdata samples the current register value (the pre-commit value if a write commits in the same cycle) and rvalid=1 in the next cycle.
  - rvalid, rdata and rresp hold until rready; arready reasserts in the following cycle.
  - Unmapped read returns UNMAPPED_RDATA with SLVERR; mapped reads return OKAY.
- Reads and writes proceed concurrently with no mutual ordering.
- Reset mid-transaction: everything returns to reset values immediately. The pending response is dropped and any half-latched write is discarded.
- cfg_ctrl and cfg_qid_map update in the cycle after the write commits (registered outputs).

Test Plan:
- Write 0x1000=0x00000001 with AW and W in the same cycle, bready=1 -> bvalid after 2 cycles, bresp=00, cfg_ctrl=0x00000001; read 0x1000 -> 0x00000001, OKAY.
- Write 0x2000=0x00020001 with AW first and W three cycles later, bready held low for 5 cycles -> awready low after the AW handshake, bvalid held stable, cfg_qid_map=0x00020001, wready returns only after B completes.
- Read 0x0000 -> 0x4D454E53 OKAY; write 0x0000=0x0 -> SLVERR, ID unchanged; read 0x3000 -> 0x00000000 SLVERR.
- Pulse pkt_inc 5 times, set err_set=0x05, then write ERR=0x01 in the same cycle as err_set[0] pulses again -> PKT_CNT=5, ERR=0x05 (set wins); write ERR=0x01 with no set -> ERR=0x04.
- Read of SCRATCH issued in the same cycle its write commits (old 0x0, new 0xA5A5A5A5) -> rdata=0x0; a subsequent read -> 0xA5A5A5A5.
- Assert reset with bvalid pending and the counter at 7 -> all outputs 0, no bvalid after release, readies high one cycle after release.
